// File: rtl/data_io_bank.sv
// Word RAM plus a bank of per-channel peripheral registers (IN/OUT/EDGE/MASK) with rising-edge interrupt.
// Latency: ReadData is combinational from DataAdr; writes land on the next Clk edge; IN lags pins by 2 cycles; Irq lags EDGE/MASK by 1 cycle.
// Backpressure: none; every access completes in one cycle, and out-of-range accesses read 0 and are otherwise ignored.
//
// Ports:
//   Clk, Reset (sync, active-low)   clock and reset
//   MemWrite, DataAdr, WriteData    single-cycle write port; bits [1:0] of DataAdr are ignored for decode
//   ReadData                        zero-latency read of the addressed RAM word or register
//   peripheralsIn / peripheralsOut  channel c at [c*PW +: PW]; inputs are asynchronous, outputs come straight from OUT
//   Irq                             registered OR of (EDGE & MASK) across all channels
module data_io_bank #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 64,
    parameter int          CHANNELS = 4,
    parameter int          PW       = 8,
    parameter logic [31:0] IO_BASE  = 32'h0000_0400
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     MemWrite,
    input  logic [31:0]              DataAdr,
    input  logic [DATA_W-1:0]        WriteData,
    output logic [DATA_W-1:0]        ReadData,
    input  logic [CHANNELS*PW-1:0]   peripheralsIn,
    output logic [CHANNELS*PW-1:0]   peripheralsOut,
    output logic                     Irq
);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          NB        = CHANNELS * PW;
    localparam logic [31:0] RAM_LIMIT = 32'(DEPTH * 4);
    localparam logic [31:0] IO_LIMIT  = IO_BASE + 32'(16 * CHANNELS);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;
    logic [NB-1:0] prev_q,  prev_d;
    logic [NB-1:0] edge_q,  edge_d;
    logic [NB-1:0] out_q,   out_d;
    logic [NB-1:0] mask_q,  mask_d;
    logic          irq_q,   irq_d;
    logic [1:0]    warm_q,  warm_d;

    logic                ram_hit;
    logic                io_hit;
    logic [AW-1:0]       word_idx;
    logic [29:0]         io_word;
    logic [1:0]          reg_sel;
    logic [CHANNELS-1:0] ch_sel;
    logic [NB-1:0]       edge_clr;
    logic [NB-1:0]       rise;

    // Address decode. The RAM window is checked first, so if the two regions
    // ever overlap the RAM takes the access.
    assign ram_hit  = (DataAdr < RAM_LIMIT);
    assign io_hit   = !ram_hit && (DataAdr >= IO_BASE) && (DataAdr < IO_LIMIT);
    assign word_idx = DataAdr[AW+1:2];
    assign io_word  = DataAdr[31:2] - IO_BASE[31:2];
    assign reg_sel  = io_word[1:0];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ch_sel[c] = io_hit && (io_word[29:2] == 28'(c));
        end
    end

    // Read mux; PW-bit registers are zero-extended.
    always_comb begin
        ReadData = '0;
        if (ram_hit) begin
            ReadData = mem_q[word_idx];
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_sel[c]) begin
                    case (reg_sel)
                        2'd0:    ReadData = DATA_W'(sync2_q[c*PW +: PW]);
                        2'd1:    ReadData = DATA_W'(out_q[c*PW +: PW]);
                        2'd2:    ReadData = DATA_W'(edge_q[c*PW +: PW]);
                        default: ReadData = DATA_W'(mask_q[c*PW +: PW]);
                    endcase
                end
            end
        end
    end

    // Register next-state. Edge detection stays disabled for three cycles
    // after reset so the synchroniser and prev stage fill with the real pin
    // level first; pins already high through reset never register as edges.
    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        edge_clr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (MemWrite && ch_sel[c]) begin
                case (reg_sel)
                    2'd1:    out_d[c*PW +: PW]    = WriteData[PW-1:0];
                    2'd2:    edge_clr[c*PW +: PW] = WriteData[PW-1:0];
                    2'd3:    mask_d[c*PW +: PW]   = WriteData[PW-1:0];
                    default: ;
                endcase
            end
        end
        sync1_d = peripheralsIn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        rise    = (warm_q == 2'd3) ? (sync2_q & ~prev_q) : '0;
        // Hardware set beats a simultaneous write-1-to-clear.
        edge_d  = (edge_q & ~edge_clr) | rise;
        irq_d   = |(edge_q & mask_q);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            edge_q  <= '0;
            out_q   <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            edge_q  <= edge_d;
            out_q   <= out_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
            warm_q  <= warm_d;
        end
    end

    // RAM contents survive reset; only the write is blocked while in reset.
    always_ff @(posedge Clk) begin
        if (Reset && MemWrite && ram_hit) begin
            mem_q[word_idx] <= WriteData;
        end
    end

    assign peripheralsOut = out_q;
    assign Irq            = irq_q;

endmodule

// File: tb/tb_data_io_bank.sv
module tb_data_io_bank;
    logic        Clk;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] peripheralsIn;
    logic [31:0] peripheralsOut;
    logic        Irq;

    int checks;
    int failures;

    data_io_bank dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .MemWrite       (MemWrite),
        .DataAdr        (DataAdr),
        .WriteData      (WriteData),
        .ReadData       (ReadData),
        .peripheralsIn  (peripheralsIn),
        .peripheralsOut (peripheralsOut),
        .Irq            (Irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic [31:0] pout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        MemWrite = 1'b0;
        DataAdr  = adr;
        #1;
        check(name, ReadData, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = wd;
        step();
        MemWrite  = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        Reset         = 1'b0;
        MemWrite      = 1'b0;
        DataAdr       = 32'h0;
        WriteData     = 32'h0;
        peripheralsIn = 32'h0;

        // Reset state
        step();
        step();
        check("rst_pout", peripheralsOut, 32'h0);
        check("rst_irq", {31'b0, Irq}, 32'h0);
        rd(32'h408, 32'h0, "rst_edge0");
        rd(32'h434, 32'h0, "rst_out3");
        Reset = 1'b1;
        repeat (4) step();

        // we, adr, wd, chk_rd, rd (before edge), pout (after edge)
        vecs.push_back('{1'b1, 32'h008, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0000_0000});
        vecs.push_back('{1'b0, 32'h008, 32'h0,        1'b1, 32'hDEADBEEF, 32'h0000_0000});
        vecs.push_back('{1'b0, 32'h100, 32'h0,        1'b1, 32'h0,        32'h0000_0000});
        vecs.push_back('{1'b1, 32'h000, 32'h111,      1'b0, 32'h0,        32'h0000_0000});
        vecs.push_back('{1'b1, 32'h414, 32'h1A5,      1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b0, 32'h414, 32'h0,        1'b1, 32'hA5,       32'h0000_A500});
        vecs.push_back('{1'b1, 32'h0FC, 32'h12345678, 1'b0, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b0, 32'h0FC, 32'h0,        1'b1, 32'h12345678, 32'h0000_A500});
        vecs.push_back('{1'b1, 32'h100, 32'h55,       1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b0, 32'h000, 32'h0,        1'b1, 32'h111,      32'h0000_A500});
        vecs.push_back('{1'b0, 32'h008, 32'h0,        1'b1, 32'hDEADBEEF, 32'h0000_A500});
        vecs.push_back('{1'b1, 32'h410, 32'hFF,       1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b0, 32'h410, 32'h0,        1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b1, 32'h43C, 32'h3C,       1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b0, 32'h43C, 32'h0,        1'b1, 32'h3C,       32'h0000_A500});
        vecs.push_back('{1'b1, 32'h428, 32'h77,       1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b1, 32'h440, 32'h99,       1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b0, 32'h440, 32'h0,        1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b0, 32'h3FC, 32'h0,        1'b1, 32'h0,        32'h0000_A500});
        vecs.push_back('{1'b1, 32'h434, 32'hFFFFFF11, 1'b1, 32'h0,        32'h1100_A500});
        vecs.push_back('{1'b0, 32'h434, 32'h0,        1'b1, 32'h11,       32'h1100_A500});

        foreach (vecs[i]) begin
            MemWrite  = vecs[i].we;
            DataAdr   = vecs[i].adr;
            WriteData = vecs[i].wd;
            #1;
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), ReadData, vecs[i].rd);
            step();
            MemWrite = 1'b0;
            check($sformatf("vec%0d_pout", i), peripheralsOut, vecs[i].pout);
            check($sformatf("vec%0d_irq", i), {31'b0, Irq}, 32'h0);
        end

        // Rising edge on ch0 bit3 with MASK armed
        wr(32'h40C, 32'h08);
        peripheralsIn = 32'h0000_0008;
        step();
        rd(32'h400, 32'h0, "in_lat1");
        step();
        rd(32'h400, 32'h08, "in_lat2");
        rd(32'h408, 32'h0, "edge_before");
        step();
        rd(32'h408, 32'h08, "edge_set");
        check("irq_lag0", {31'b0, Irq}, 32'h0);
        step();
        check("irq_set", {31'b0, Irq}, 32'h1);

        // W1C colliding with a fresh rising edge: set wins
        peripheralsIn = 32'h0;
        repeat (3) step();
        peripheralsIn = 32'h0000_0008;
        step();
        step();
        wr(32'h408, 32'h08);
        rd(32'h408, 32'h08, "edge_set_wins");
        check("irq_hold", {31'b0, Irq}, 32'h1);
        wr(32'h408, 32'h08);
        rd(32'h408, 32'h0, "edge_w1c");
        step();
        check("irq_clr", {31'b0, Irq}, 32'h0);

        // Reset overriding a write; RAM retained
        peripheralsIn = 32'h0000_0108;
        wr(32'h41C, 32'h01);
        repeat (3) step();
        rd(32'h418, 32'h01, "edge_ch1");
        check("irq_ch1", {31'b0, Irq}, 32'h1);
        Reset     = 1'b0;
        MemWrite  = 1'b1;
        DataAdr   = 32'h424;
        WriteData = 32'hEE;
        step();
        Reset    = 1'b1;
        MemWrite = 1'b0;
        check("rst2_pout", peripheralsOut, 32'h0);
        check("rst2_irq", {31'b0, Irq}, 32'h0);
        rd(32'h424, 32'h0, "rst2_out2");
        rd(32'h418, 32'h0, "rst2_edge1");
        rd(32'h40C, 32'h0, "rst2_mask0");
        step();
        rd(32'h008, 32'hDEADBEEF, "ram_keep_008");
        rd(32'h0FC, 32'h12345678, "ram_keep_0fc");
        rd(32'h000, 32'h111, "ram_keep_000");
        repeat (4) step();
        rd(32'h418, 32'h0, "rst2_noedge1");
        rd(32'h408, 32'h0, "rst2_noedge0");

        // All inputs high through reset: no edges, IN follows after 2 cycles
        peripheralsIn = 32'hFFFF_FFFF;
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
        step();
        rd(32'h400, 32'h0, "hi_in_lat1");
        step();
        rd(32'h400, 32'hFF, "hi_in0");
        rd(32'h430, 32'hFF, "hi_in3");
        repeat (4) step();
        for (int c = 0; c < 4; c++) begin
            rd(32'h408 + 32'(c * 16), 32'h0, $sformatf("hi_noedge%0d", c));
        end
        check("hi_irq", {31'b0, Irq}, 32'h0);

        // Detection still live once settled
        peripheralsIn = 32'h00FF_FFFF;
        repeat (3) step();
        peripheralsIn = 32'hFFFF_FFFF;
        repeat (3) step();
        rd(32'h438, 32'hFF, "edge_ch3_after");
        rd(32'h408, 32'h0, "edge_ch0_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
